// File: rtl/stdout_uart_tx.sv
// Byte FIFO feeding an 8N1 serial transmitter for the core's stdout port.
// Writes are strobed in; frames go out back-to-back while the FIFO has data.
module stdout_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          txd,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);
  localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      sh_q, sh_d;
  logic            txd_q, txd_d;
  logic [AW-1:0]   wp_q, wp_d, rp_q, rp_d;
  logic [LW-1:0]   level_q, level_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      mem [FIFO_DEPTH];

  logic push, pop, baud_last, have_data;

  assign full      = (level_q == DEPTH_L);
  assign empty     = (level_q == '0) && (state_q == S_IDLE);
  assign level     = level_q;
  assign overflow  = ovf_q;
  assign txd       = txd_q;
  assign have_data = (level_q != '0);
  assign baud_last = (cnt_q == BAUD_MAX);
  // A write against a full FIFO is dropped even if a pop frees a slot this edge.
  assign push      = wr_en && !full;

  always_comb begin
    state_d = state_q;
    cnt_d   = baud_last ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    sh_d    = sh_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (have_data) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_last) begin
          state_d = S_DATA;
          idx_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (baud_last) begin
          if (idx_q == 3'd7) state_d = S_STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      S_STOP: begin
        if (baud_last) begin
          if (have_data) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (pop) sh_d = mem[rp_q];

    // Line follows the current state one cycle later, keeping txd a pure flop.
    case (state_q)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = sh_q[idx_q];
      default: txd_d = 1'b1;
    endcase

    wp_d    = push ? wp_q + 1'b1 : wp_q;
    rp_d    = pop  ? rp_q + 1'b1 : rp_q;
    level_d = level_q;
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (!push && pop) level_d = level_q - LW'(1);
    ovf_d   = ovf_q | (wr_en & full);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      txd_q   <= 1'b1;
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      txd_q   <= txd_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) mem[wp_q] <= wr_data;
  end

endmodule

// File: tb/tb_stdout_uart_tx.sv
// Randomized and directed bench for stdout_uart_tx, checked every cycle against
// a frame-level model (byte queue plus frame start times).
module tb_stdout_uart_tx;
  localparam int C = 4;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       txd, full, empty, overflow;
  logic [2:0] level;

  int total = 0;
  int bad   = 0;

  stdout_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .txd(txd), .full(full), .empty(empty), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Line level for a frame whose START began k cycles ago.
  function automatic logic line_of(input bit act, input int k, input logic [7:0] b);
    int pos;
    if (!act) return 1'b1;
    pos = k / C;
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
    return 1'b1;
  endfunction

  // Model: queue of pending bytes; a frame occupies 10*C edges from its pop edge.
  logic [7:0] q[$];
  bit         valid = 0, active = 0, m_ovf = 0;
  int         t = 0, cur_start = 0;
  logic [7:0] cur_byte = 8'h00;
  logic       line = 1'b1, exp_txd = 1'b1;

  initial begin
    int  lvl;
    bit  fin, pp;
    forever begin
      @(negedge clk);
      if (valid) begin
        chk("txd", txd, exp_txd);
        chk("level", level, q.size());
        chk("full", full, q.size() == D);
        chk("empty", empty, (q.size() == 0) && !active);
        chk("overflow", overflow, m_ovf);
      end
      t++;
      if (reset) begin
        q.delete();
        active  = 0;
        m_ovf   = 0;
        line    = 1'b1;
        exp_txd = 1'b1;
        valid   = 1;
      end else begin
        exp_txd = line;
        lvl = q.size();
        fin = active && (t == cur_start + 10*C);
        pp  = (lvl > 0) && (!active || fin);
        if (fin && !pp) active = 0;
        if (pp) begin
          cur_byte  = q.pop_front();
          active    = 1;
          cur_start = t;
        end
        if (wr_en) begin
          if (lvl < D) q.push_back(wr_data);
          else         m_ovf = 1;
        end
        line = line_of(active, t - cur_start, cur_byte);
      end
    end
  end

  // Apply inputs for exactly one rising edge; returns just after that edge.
  task automatic drive(input logic r, input logic w, input logic [7:0] d);
    reset = r; wr_en = w; wr_data = d;
    @(posedge clk); #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'($urandom));
  endtask

  initial begin
    int exp_bits[8] = '{1, 0, 0, 0, 0, 0, 1, 0};
    int lows;
    logic [7:0] b;
    logic r, w;
    reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
    @(posedge clk); #2;
    drive(1'b1, 1'b1, 8'hFF);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    chk("rst_txd", txd, 1);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", overflow, 0);
    idle(3);

    // Single byte 0x41: literal waveform
    drive(1'b0, 1'b1, 8'h41);
    for (int j = 1; j <= 44; j++) begin
      idle(1);
      if (j == 1)                chk("f41_pre", txd, 1);
      else if (j <= 5)           chk("f41_start", txd, 0);
      else if (j <= 37)          chk("f41_data", txd, exp_bits[(j-6)/4]);
      else if (j <= 41)          chk("f41_stop", txd, 1);
    end
    chk("f41_empty", empty, 1);

    // Burst of six: fills, drops the last
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 8'h10 + 8'(i));
      if (i == 4) begin
        chk("burst_level", level, 4);
        chk("burst_full", full, 1);
      end
      if (i == 5) chk("burst_ovf", overflow, 1);
    end
    idle(205);
    chk("burst_drained", empty, 1);
    drive(1'b1, 1'b0, 8'h00);
    chk("ovf_cleared", overflow, 0);
    idle(3);

    // Write in the final stop cycle with an empty FIFO
    drive(1'b0, 1'b1, 8'hA5);
    idle(40);
    drive(1'b0, 1'b1, 8'h3C);
    chk("laststop_txd", txd, 1);
    idle(1);
    chk("idle_gap_txd", txd, 1);
    idle(1);
    chk("restart_txd", txd, 0);
    idle(50);

    // Reset during DATA bit 3, with a write on the reset edge
    drive(1'b0, 1'b1, 8'h00);
    idle(17);
    drive(1'b1, 1'b1, 8'h55);
    chk("abort_txd", txd, 1);
    chk("abort_level", level, 0);
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      idle(1);
      if (txd !== 1'b1) lows++;
    end
    chk("abort_quiet", lows, 0);

    // Eight bytes spaced one per frame: pointers wrap twice
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      drive(1'b0, 1'b1, b);
      idle(42);
    end

    // Random traffic: light load, then heavy load with overflow, rare resets
    for (int i = 0; i < 1600; i++) begin
      r = ($urandom_range(0, 599) == 0);
      w = (i < 800) ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 7) == 0);
      drive(r, w, 8'($urandom));
    end
    idle(500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stdout_uart_tx.md
STDOUT_UART_TX -- requirements
Module: stdout_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per serial bit; legal range is 2 or more.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, byte entries; legal values are powers of 2, 2 or more.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port wr_en, input, 1 bit: one-cycle strobe from the core's store to the stdout address.
REQ-006 SHALL have port wr_data, input, 8 bits: byte to send, taken from stdout[7:0].
REQ-007 SHALL have port txd, output, 1 bit: serial line, idle high.
REQ-008 SHALL have port full, output, 1 bit: FIFO holds FIFO_DEPTH bytes.
REQ-009 SHALL have port empty, output, 1 bit: FIFO empty and the state machine is IDLE.
REQ-010 SHALL have port level, output, $clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.
REQ-011 SHALL have port overflow, output, 1 bit: sticky flag that a write was dropped.

Function
REQ-012 SHALL push wr_data into the FIFO at the rising edge where wr_en=1 and the registered full=0.
REQ-013 SHALL drop a write with wr_en=1 and full=1 (even if a pop occurs that same edge) and set overflow=1 until reset.
REQ-014 SHALL leave level unchanged on a simultaneous push and pop; pop SHALL never occur when level=0.
REQ-015 SHALL use FIFO pointers that wrap modulo FIFO_DEPTH; full is level==FIFO_DEPTH, and no byte is lost or duplicated across wrap.
REQ-016 SHALL implement states IDLE, START, DATA and STOP, using a baud counter that counts 0..CLKS_PER_BIT-1 and a 3-bit bit index.
REQ-017 IDLE: while level>0, SHALL pop the head byte into the shift register, clear the baud counter and go to START at the next edge.
REQ-018 START: SHALL drive txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
REQ-019 DATA: SHALL drive txd with shift-register bit[index], LSB first, each bit lasting CLKS_PER_BIT cycles; after index 7 it goes to STOP.
REQ-020 STOP: SHALL drive txd=1 for CLKS_PER_BIT cycles; on the last stop cycle it pops and goes straight to START if level>0, otherwise to IDLE.
REQ-021 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles, with no idle gap between back-to-back frames.
REQ-022 Latency: with an empty FIFO in IDLE, a write at edge n SHALL make txd go low from edge n+2.
REQ-023 SHALL register txd, with no combinational path from any input to txd.
REQ-024 wr_en SHALL be the only write qualifier; wr_data is ignored when wr_en=0.

Reset
REQ-025 While reset=1 at an edge, the block SHALL go to IDLE and set txd=1, level=0, full=0, empty=1, overflow=0; pointers, baud counter and bit index SHALL be 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame: txd=1 from the next edge, FIFO contents discarded, no further frames.
REQ-027 A write with wr_en=1 in the same cycle as reset=1 SHALL be discarded.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-028 Reset -> txd=1, empty=1, full=0, level=0, overflow=0.
REQ-029 Single write 0x41 at edge n -> txd=0 on edges n+2..n+5, then bits 1,0,0,0,0,0,1,0 for 4 cycles each, stop bit high for 4 cycles; empty=1 after 40 cycles.
REQ-030 Writes 0x10..0x15 in six consecutive cycles -> 0x10 popped at the second edge; level reaches 4, full=1; 0x15 dropped with overflow=1; exactly five contiguous frames 0x10..0x14 over 200 cycles.
REQ-031 Write during the final stop-bit cycle of a frame, with an empty FIFO -> IDLE for 1 cycle, then START; with a non-empty FIFO the next frame's START immediately follows STOP with no gap.
REQ-032 Reset asserted during DATA bit 3 -> txd=1 at the next edge, level=0, no further txd low for 100 cycles.
REQ-033 Eight writes spaced one per frame -> read pointer wraps twice; the eight transmitted bytes match in order with no loss or duplication.
